pll_drp_reconfig: RTL and testbench

- Parametrised dynamic-reconfiguration sequencer for the simulated PLLE2/MMCME2 models.
- Reprograms the CLKFBOUT multiplier and up to 6 CLKOUTn dividers at runtime over the DRP (DADDR/DEN/DWE/DI/DO/DRDY).
- Holds the PLL in reset during the update, then waits for LOCKED.
- Sits between user control logic and the pll instance and drives the pll's RST and DRP ports.

---
 rtl/pll_drp_pkg.sv | 45 ++++
 rtl/pll_drp_reconfig_if.sv | 14 +
 rtl/pll_drp_divcalc.sv | 26 ++
 rtl/pll_drp_reconfig.sv | 224 ++++++++++++++++++++++
 tb/tb_pll_drp_reconfig.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_drp_pkg.sv
// Shared types and constants for the PLL/MMCM DRP reconfiguration sequencer.
// Register addresses and field layout follow the PLLE2/MMCME2 ClkReg1/ClkReg2 map.
package pll_drp_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ASSERT_RST,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_WR_WAIT,
        S_VFY,
        S_VFY_WAIT,
        S_NEXT,
        S_RELEASE,
        S_WAIT_LOCK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [6:0]  CLKFB_BASE     = 7'h14;
    localparam logic [6:0]  CLKOUT_BASE    = 7'h08;
    localparam logic [15:0] REG1_KEEP_MASK = 16'h1000;
    localparam logic [15:0] REG2_KEEP_MASK = 16'hFC00;

    localparam int unsigned HIGH_POS    = 6;
    localparam int unsigned LOW_POS     = 0;
    localparam int unsigned EDGE_POS    = 7;
    localparam int unsigned NOCOUNT_POS = 6;

    localparam logic [6:0] DIV_MIN = 7'd1;
    localparam logic [6:0] DIV_MAX = 7'd126;

    function automatic logic div_illegal(input logic [6:0] d);
        return (d < DIV_MIN) || (d > DIV_MAX);
    endfunction

    // Channel 0 is CLKFBOUT; channel n>0 is CLKOUT(n-1). reg2 sits at reg1+1.
    function automatic logic [6:0] chan_addr(input logic [2:0] ch, input logic reg_sel);
        logic [6:0] base;
        base = (ch == 3'd0) ? CLKFB_BASE : CLKOUT_BASE + 7'({ch - 3'd1, 1'b0});
        return base | 7'(reg_sel);
    endfunction

endpackage

// File: rtl/pll_drp_reconfig_if.sv
// DRP bus between the reconfiguration sequencer (master) and the PLL primitive (slave).
interface pll_drp_reconfig_if;

    logic [6:0]  DADDR;
    logic        DEN;
    logic        DWE;
    logic [15:0] DI;
    logic [15:0] DO;
    logic        DRDY;

    modport master (output DADDR, DEN, DWE, DI, input DO, DRDY);
    modport slave  (input DADDR, DEN, DWE, DI, output DO, DRDY);

endinterface

// File: rtl/pll_drp_divcalc.sv
// Combinational divide-value to counter-field conversion for one PLL output counter.
module pll_drp_divcalc import pll_drp_pkg::*; (
    input  logic [6:0] d,
    output logic [5:0] high,
    output logic [5:0] low,
    output logic       edge_bit,
    output logic       no_count,
    output logic       illegal
);

    always_comb begin
        illegal  = div_illegal(d);
        no_count = (d == 7'd1);
        // Divide-by-1 bypasses the counter, so the edge bit carries no meaning and is cleared.
        if (no_count) begin
            high     = 6'd1;
            low      = 6'd1;
            edge_bit = 1'b0;
        end else begin
            high     = d[6:1];
            low      = 6'(d - 7'(d[6:1]));
            edge_bit = d[0];
        end
    end

endmodule

// File: rtl/pll_drp_reconfig.sv
// DRP reconfiguration sequencer: rewrites CLKFBOUT and NUM_CH CLKOUTn counters with the PLL held in reset.
// Optional readback check of every write is enabled by defining PLL_DRP_READBACK_VERIFY_EN.
module pll_drp_reconfig import pll_drp_pkg::*; #(
    parameter int unsigned NUM_CH       = 6,
    parameter int unsigned DRDY_TIMEOUT = 64,
    parameter int unsigned LOCK_TIMEOUT = 4096
) (
    input  logic                  DCLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [6:0]            MULT,
    input  logic [7*NUM_CH-1:0]   DIVIDE,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic                  PLL_RST,
    input  logic                  LOCKED,
    pll_drp_reconfig_if.master    drp
);

    localparam int unsigned TMO_MAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(TMO_MAX) + 1;
    localparam logic [TMR_W-1:0] DRDY_LAST = TMR_W'(DRDY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [2:0]       LAST_CH   = 3'(NUM_CH);

    state_t                  state;
    logic [6:0]              mult_q;
    logic [NUM_CH-1:0][6:0]  div_q;
    logic [2:0]              ch;
    logic                    reg_sel;
    logic [TMR_W-1:0]        tmr;
    logic                    lock_seen_low;

    logic [6:0]              d_cur;
    logic [5:0]              f_high;
    logic [5:0]              f_low;
    logic                    f_edge;
    logic                    f_nocount;
    logic                    f_illegal;
    logic                    start_illegal;
    logic [15:0]             new_val;

    always_comb begin
        start_illegal = div_illegal(MULT);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (div_illegal(DIVIDE[7*i +: 7])) start_illegal = 1'b1;
        end
    end

    always_comb begin
        d_cur = mult_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(ch) == i + 1) d_cur = div_q[i];
        end
    end

    pll_drp_divcalc u_divcalc (
        .d        (d_cur),
        .high     (f_high),
        .low      (f_low),
        .edge_bit (f_edge),
        .no_count (f_nocount),
        .illegal  (f_illegal)
    );

    // Merge the freshly computed fields into the bits of the register that must be preserved.
    always_comb begin
        if (!reg_sel) begin
            new_val = (drp.DO & REG1_KEEP_MASK) | (16'(f_high) << HIGH_POS) | (16'(f_low) << LOW_POS);
        end else begin
            new_val = (drp.DO & REG2_KEEP_MASK) | (16'(f_edge) << EDGE_POS)
                    | (16'(f_nocount) << NOCOUNT_POS);
        end
    end

    always_ff @(posedge DCLK) begin
        if (!RST_N) begin
            state         <= S_IDLE;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            ERR           <= 1'b0;
            PLL_RST       <= 1'b0;
            drp.DADDR     <= '0;
            drp.DEN       <= 1'b0;
            drp.DWE       <= 1'b0;
            drp.DI        <= '0;
            mult_q        <= '0;
            div_q         <= '0;
            ch            <= '0;
            reg_sel       <= 1'b0;
            tmr           <= '0;
            lock_seen_low <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (tmr != '1) tmr <= tmr + 1'b1;

            case (state)
                S_IDLE: begin
                    if (START) begin
                        mult_q  <= MULT;
                        div_q   <= DIVIDE;
                        ch      <= '0;
                        reg_sel <= 1'b0;
                        tmr     <= '0;
                        BUSY    <= 1'b1;
                        ERR     <= 1'b0;
                        if (start_illegal) begin
                            state <= S_ERROR;
                        end else begin
                            PLL_RST <= 1'b1;
                            state   <= S_ASSERT_RST;
                        end
                    end
                end
                S_ASSERT_RST: begin
                    drp.DADDR <= chan_addr(3'd0, 1'b0);
                    drp.DEN   <= 1'b1;
                    drp.DWE   <= 1'b0;
                    state     <= S_RD;
                end
                S_RD: begin
                    drp.DEN <= 1'b0;
                    tmr     <= '0;
                    state   <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (drp.DRDY) begin
                        if (f_illegal) begin
                            state <= S_ERROR;
                        end else begin
                            drp.DI  <= new_val;
                            drp.DEN <= 1'b1;
                            drp.DWE <= 1'b1;
                            state   <= S_WR;
                        end
                    end else if (tmr == DRDY_LAST) begin
                        state <= S_ERROR;
                    end
                end
                S_WR: begin
                    drp.DEN <= 1'b0;
                    drp.DWE <= 1'b0;
                    tmr     <= '0;
                    state   <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (drp.DRDY) begin
`ifdef PLL_DRP_READBACK_VERIFY_EN
                        drp.DEN <= 1'b1;
                        state   <= S_VFY;
`else
                        state   <= S_NEXT;
`endif
                    end else if (tmr == DRDY_LAST) begin
                        state <= S_ERROR;
                    end
                end
`ifdef PLL_DRP_READBACK_VERIFY_EN
                S_VFY: begin
                    drp.DEN <= 1'b0;
                    tmr     <= '0;
                    state   <= S_VFY_WAIT;
                end
                S_VFY_WAIT: begin
                    if (drp.DRDY) begin
                        state <= (drp.DO != drp.DI) ? S_ERROR : S_NEXT;
                    end else if (tmr == DRDY_LAST) begin
                        state <= S_ERROR;
                    end
                end
`endif
                S_NEXT: begin
                    if (!reg_sel) begin
                        reg_sel   <= 1'b1;
                        drp.DADDR <= chan_addr(ch, 1'b1);
                        drp.DEN   <= 1'b1;
                        state     <= S_RD;
                    end else if (ch == LAST_CH) begin
                        PLL_RST <= 1'b0;
                        state   <= S_RELEASE;
                    end else begin
                        ch        <= ch + 3'd1;
                        reg_sel   <= 1'b0;
                        drp.DADDR <= chan_addr(ch + 3'd1, 1'b0);
                        drp.DEN   <= 1'b1;
                        state     <= S_RD;
                    end
                end
                S_RELEASE: begin
                    tmr           <= '0;
                    lock_seen_low <= 1'b0;
                    state         <= S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    // A stale LOCKED from before the reset must drop once before a rise counts.
                    if (!LOCKED) lock_seen_low <= 1'b1;
                    if (LOCKED && lock_seen_low) begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= S_DONE;
                    end else if (tmr == LOCK_LAST) begin
                        state <= S_ERROR;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                S_ERROR: begin
                    ERR     <= 1'b1;
                    BUSY    <= 1'b0;
                    PLL_RST <= 1'b0;
                    drp.DEN <= 1'b0;
                    drp.DWE <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Directed self-checking bench for pll_drp_reconfig with a behavioural DRP register-file responder.
module tb_pll_drp_reconfig;

    localparam int unsigned NCH = 2;

    logic             DCLK = 1'b0;
    logic             RST_N;
    logic             START;
    logic [6:0]       MULT;
    logic [7*NCH-1:0] DIVIDE;
    logic             BUSY;
    logic             DONE;
    logic             ERR;
    logic             PLL_RST;
    logic             LOCKED;

    int tests  = 0;
    int failed = 0;

    pll_drp_reconfig_if drp_bus ();

    pll_drp_reconfig #(.NUM_CH(NCH), .DRDY_TIMEOUT(64), .LOCK_TIMEOUT(4096)) dut (
        .DCLK    (DCLK),
        .RST_N   (RST_N),
        .START   (START),
        .MULT    (MULT),
        .DIVIDE  (DIVIDE),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR     (ERR),
        .PLL_RST (PLL_RST),
        .LOCKED  (LOCKED),
        .drp     (drp_bus)
    );

    always #5 DCLK = ~DCLK;

    // DRP responder: DRDY three cycles after DEN; reads return register contents.
    logic [15:0] mem [0:127];
    logic [6:0]  wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    bit          no_resp;
    bit          corrupt08;
    bit          written08;
    bit          pend;
    int          cnt;
    int          den_cnt;
    int          rst_low_den;
    int          done_cnt;

    always @(posedge DCLK) begin
        drp_bus.DRDY <= 1'b0;
        if (pend) begin
            if (cnt == 0) begin
                drp_bus.DRDY <= 1'b1;
                pend = 1'b0;
            end else begin
                cnt = cnt - 1;
            end
        end
        if (drp_bus.DEN === 1'b1) begin
            den_cnt++;
            if (PLL_RST !== 1'b1) rst_low_den++;
            if (!no_resp) begin
                pend = 1'b1;
                cnt  = 1;
            end
            if (drp_bus.DWE === 1'b1) begin
                mem[drp_bus.DADDR] = drp_bus.DI;
                wr_addr_q.push_back(drp_bus.DADDR);
                wr_data_q.push_back(drp_bus.DI);
                if (drp_bus.DADDR == 7'h08) written08 = 1'b1;
            end else if (corrupt08 && written08 && drp_bus.DADDR == 7'h08) begin
                drp_bus.DO <= mem[drp_bus.DADDR] ^ 16'h0001;
            end else begin
                drp_bus.DO <= mem[drp_bus.DADDR];
            end
        end
    end

    always @(posedge DCLK) if (DONE === 1'b1) done_cnt++;

    task automatic tick(input int n);
        repeat (n) @(negedge DCLK);
    endtask

    task automatic model_reset(input logic [15:0] fill);
        for (int i = 0; i < 128; i++) mem[i] = fill;
        wr_addr_q.delete();
        wr_data_q.delete();
        no_resp     = 1'b0;
        corrupt08   = 1'b0;
        written08   = 1'b0;
        pend        = 1'b0;
        den_cnt     = 0;
        rst_low_den = 0;
        done_cnt    = 0;
    endtask

    task automatic pulse_start(input logic [6:0] m, input logic [7*NCH-1:0] d);
        @(negedge DCLK);
        START  = 1'b1;
        MULT   = m;
        DIVIDE = d;
        @(negedge DCLK);
        START  = 1'b0;
    endtask

    task automatic wait_rst_release(input string tag);
        int n = 0;
        while (PLL_RST !== 1'b0 && n < 600) begin
            @(negedge DCLK);
            n++;
        end
        tests++;
        if (n >= 600) begin
            failed++;
            $display("FAIL %s_release: PLL_RST still %b after %0d cycles, expected 0", tag, PLL_RST, n);
        end
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        START = 1'b0;
        LOCKED = 1'b0;
        MULT = '0;
        DIVIDE = '0;
        model_reset(16'h0000);
        tick(3);
        tests++;
        if ({BUSY, DONE, ERR, PLL_RST, drp_bus.DEN, drp_bus.DWE} !== 6'b0) begin
            failed++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {BUSY, DONE, ERR, PLL_RST, drp_bus.DEN, drp_bus.DWE});
        end
        tests++;
        if (drp_bus.DADDR !== 7'h00) begin
            failed++;
            $display("FAIL reset_daddr: got %h expected 00", drp_bus.DADDR);
        end
        tests++;
        if (drp_bus.DI !== 16'h0000) begin
            failed++;
            $display("FAIL reset_di: got %h expected 0000", drp_bus.DI);
        end
        RST_N = 1'b1;
        tick(2);
    endtask

    task automatic test_reconfig;
        logic [6:0]  ea [8] = '{7'h14, 7'h15, 7'h08, 7'h09, 7'h0A, 7'h0B, 7'h00, 7'h00};
        logic [15:0] ed [8] = '{16'h0083, 16'h0080, 16'h0083, 16'h0080, 16'h0082, 16'h0000, 16'h0, 16'h0};
        int n;
        model_reset(16'h0000);
        LOCKED = 1'b0;
        pulse_start(7'd5, {7'd4, 7'd5});
        tests++;
        if ({BUSY, ERR, PLL_RST} !== 3'b101) begin
            failed++;
            $display("FAIL start_accept: BUSY/ERR/PLL_RST=%b expected 101", {BUSY, ERR, PLL_RST});
        end
        tick(4);
        pulse_start(7'd9, {7'd9, 7'd9});
        wait_rst_release("reconfig");
        tests++;
        if (wr_addr_q.size() != 6) begin
            failed++;
            $display("FAIL reconfig_nwr: got %0d writes expected 6", wr_addr_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
                failed++;
                if (i < wr_addr_q.size())
                    $display("FAIL reconfig_wr%0d: got %h<=%h expected %h<=%h", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]);
                else
                    $display("FAIL reconfig_wr%0d: got none expected %h<=%h", i, ea[i], ed[i]);
            end
        end
        tests++;
`ifdef PLL_DRP_READBACK_VERIFY_EN
        if (den_cnt != 18) begin
            failed++;
            $display("FAIL reconfig_nden: got %0d expected 18", den_cnt);
        end
`else
        if (den_cnt != 12) begin
            failed++;
            $display("FAIL reconfig_nden: got %0d expected 12", den_cnt);
        end
`endif
        tests++;
        if (rst_low_den != 0) begin
            failed++;
            $display("FAIL reconfig_pllrst: %0d DRP accesses with PLL_RST low, expected 0", rst_low_den);
        end
        tick(100);
        tests++;
        if (BUSY !== 1'b1 || done_cnt != 0) begin
            failed++;
            $display("FAIL reconfig_wait_lock: BUSY=%b dones=%0d expected 1/0", BUSY, done_cnt);
        end
        LOCKED = 1'b1;
        n = 0;
        while (DONE !== 1'b1 && n < 20) begin
            @(negedge DCLK);
            n++;
        end
        tests++;
        if (n >= 20) begin
            failed++;
            $display("FAIL reconfig_done: DONE=%b after lock, expected 1", DONE);
        end
        tick(1);
        tests++;
        if ({DONE, BUSY, ERR} !== 3'b000 || done_cnt != 1) begin
            failed++;
            $display("FAIL reconfig_end: DONE/BUSY/ERR=%b dones=%0d expected 000/1", {DONE, BUSY, ERR}, done_cnt);
        end
        LOCKED = 1'b0;
        tick(2);
    endtask

    task automatic test_divide_edges;
        logic [6:0]  ea [6] = '{7'h14, 7'h15, 7'h08, 7'h09, 7'h0A, 7'h0B};
        logic [15:0] ed [6] = '{16'h1145, 16'hFC00, 16'h1041, 16'hFC40, 16'h1FFF, 16'hFC00};
        int n;
        model_reset(16'hFFFF);
        LOCKED = 1'b0;
        pulse_start(7'd10, {7'd126, 7'd1});
        wait_rst_release("div_edges");
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
                failed++;
                if (i < wr_addr_q.size())
                    $display("FAIL div_edges_wr%0d: got %h<=%h expected %h<=%h", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]);
                else
                    $display("FAIL div_edges_wr%0d: got none expected %h<=%h", i, ea[i], ed[i]);
            end
        end
        tick(3);
        LOCKED = 1'b1;
        n = 0;
        while (DONE !== 1'b1 && n < 20) begin
            @(negedge DCLK);
            n++;
        end
        tests++;
        if (n >= 20) begin
            failed++;
            $display("FAIL div_edges_done: DONE=%b expected 1", DONE);
        end
        LOCKED = 1'b0;
        tick(2);
    endtask

    task automatic test_stale_lock;
        int n;
        model_reset(16'h0000);
        LOCKED = 1'b1;
        pulse_start(7'd5, {7'd4, 7'd5});
        wait_rst_release("stale_lock");
        tick(20);
        tests++;
        if (BUSY !== 1'b1 || done_cnt != 0) begin
            failed++;
            $display("FAIL stale_lock_hold: BUSY=%b dones=%0d expected 1/0", BUSY, done_cnt);
        end
        LOCKED = 1'b0;
        tick(2);
        LOCKED = 1'b1;
        n = 0;
        while (DONE !== 1'b1 && n < 20) begin
            @(negedge DCLK);
            n++;
        end
        tests++;
        if (n >= 20) begin
            failed++;
            $display("FAIL stale_lock_done: DONE=%b after fresh lock, expected 1", DONE);
        end
        LOCKED = 1'b0;
        tick(2);
    endtask

    task automatic test_illegal;
        logic [6:0]       vm [3] = '{7'd0, 7'd5, 7'd5};
        logic [7*NCH-1:0] vd [3] = '{{7'd4, 7'd5}, {7'd127, 7'd5}, {7'd4, 7'd0}};
        for (int v = 0; v < 3; v++) begin
            model_reset(16'h0000);
            pulse_start(vm[v], vd[v]);
            tests++;
            if ({BUSY, ERR} !== 2'b10) begin
                failed++;
                $display("FAIL illegal%0d_accept: BUSY/ERR=%b expected 10", v, {BUSY, ERR});
            end
            tick(1);
            tests++;
            if ({ERR, BUSY, PLL_RST} !== 3'b100) begin
                failed++;
                $display("FAIL illegal%0d_err: ERR/BUSY/PLL_RST=%b expected 100", v, {ERR, BUSY, PLL_RST});
            end
            tick(5);
            tests++;
            if (den_cnt != 0 || PLL_RST !== 1'b0 || ERR !== 1'b1) begin
                failed++;
                $display("FAIL illegal%0d_quiet: den=%0d PLL_RST=%b ERR=%b expected 0/0/1", v, den_cnt, PLL_RST, ERR);
            end
        end
    endtask

    task automatic test_drdy_timeout;
        int n;
        model_reset(16'h0000);
        no_resp = 1'b1;
        pulse_start(7'd5, {7'd4, 7'd5});
        n = 0;
        while (drp_bus.DEN !== 1'b1 && n < 10) begin
            @(negedge DCLK);
            n++;
        end
        n = 0;
        while (ERR !== 1'b1 && n < 200) begin
            @(negedge DCLK);
            n++;
        end
        tests++;
        if (n < 64 || n > 68) begin
            failed++;
            $display("FAIL drdy_timeout_time: ERR after %0d cycles from DEN, expected 64..68", n);
        end
        tick(3);
        tests++;
        if ({ERR, BUSY, PLL_RST} !== 3'b100 || done_cnt != 0 || den_cnt != 1) begin
            failed++;
            $display("FAIL drdy_timeout_state: ERR/BUSY/PLL_RST=%b dones=%0d den=%0d expected 100/0/1",
                     {ERR, BUSY, PLL_RST}, done_cnt, den_cnt);
        end
        no_resp = 1'b0;
        tick(2);
    endtask

    task automatic test_reset_mid;
        int n;
        model_reset(16'h0000);
        LOCKED = 1'b0;
        pulse_start(7'd5, {7'd4, 7'd5});
        n = 0;
        while (!(drp_bus.DEN === 1'b1 && drp_bus.DWE === 1'b1) && n < 50) begin
            @(negedge DCLK);
            n++;
        end
        tick(1);
        RST_N = 1'b0;
        tick(1);
        tests++;
        if ({BUSY, DONE, ERR, PLL_RST, drp_bus.DEN, drp_bus.DWE} !== 6'b0 || drp_bus.DADDR !== 7'h00
            || drp_bus.DI !== 16'h0000) begin
            failed++;
            $display("FAIL reset_mid: ctrl=%b DADDR=%h DI=%h expected 000000/00/0000",
                     {BUSY, DONE, ERR, PLL_RST, drp_bus.DEN, drp_bus.DWE}, drp_bus.DADDR, drp_bus.DI);
        end
        RST_N = 1'b1;
        tick(5);
        model_reset(16'h0000);
        pulse_start(7'd5, {7'd4, 7'd5});
        wait_rst_release("reset_mid");
        tests++;
        if (wr_addr_q.size() != 6 || wr_data_q[0] !== 16'h0083 || wr_addr_q[5] !== 7'h0B) begin
            failed++;
            $display("FAIL reset_mid_rerun: %0d writes, expected 6 starting 14<=0083", wr_addr_q.size());
        end
        tick(2);
        LOCKED = 1'b1;
        n = 0;
        while (DONE !== 1'b1 && n < 20) begin
            @(negedge DCLK);
            n++;
        end
        tests++;
        if (n >= 20 || ERR !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_done: DONE=%b ERR=%b expected 1/0", DONE, ERR);
        end
        LOCKED = 1'b0;
        tick(2);
    endtask

`ifdef PLL_DRP_READBACK_VERIFY_EN
    task automatic test_readback_verify;
        int n;
        model_reset(16'h0000);
        corrupt08 = 1'b1;
        LOCKED = 1'b0;
        pulse_start(7'd5, {7'd4, 7'd5});
        n = 0;
        while (ERR !== 1'b1 && n < 300) begin
            @(negedge DCLK);
            n++;
        end
        tick(3);
        tests++;
        if ({ERR, BUSY, PLL_RST} !== 3'b100 || done_cnt != 0) begin
            failed++;
            $display("FAIL verify_err: ERR/BUSY/PLL_RST=%b dones=%0d expected 100/0", {ERR, BUSY, PLL_RST}, done_cnt);
        end
        tests++;
        if (wr_addr_q.size() != 3) begin
            failed++;
            $display("FAIL verify_stop: %0d writes before abort, expected 3", wr_addr_q.size());
        end
        corrupt08 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_reconfig();
        test_divide_edges();
        test_stale_lock();
        test_illegal();
        test_drdy_timeout();
        test_reset_mid();
`ifdef PLL_DRP_READBACK_VERIFY_EN
        test_readback_verify();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
